uart_ring_arbiter: RTL and testbench
====================================

Name: uart_ring_arbiter

Overview:
- Shares one UARTRingBuffer between NUM_REQ byte producers using round-robin write arbitration.
- Sequences reads from the buffer on behalf of a single consumer (the UART TX path).
- The ring buffer has no full flag and silently drops writes when full, so this block keeps its own occupancy count and never issues a write the buffer would drop.
- Sits between the producer blocks and the UARTRingBuffer instance; drives all of the buffer's writeEnable, data and readEnable inputs.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_WIDTH, 8, byte width.
- CAPACITY, 3, entries the ring buffer holds before it drops writes (2^BITLENGTH - 1).
- ACK_TIMEOUT, 15, max cycles to wait for rbReadAck before aborting a read (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-producer write request; hold until granted.
- reqData  in  NUM_REQ*DATA_WIDTH  per-producer byte; slice i belongs to req[i]; hold with req.
- grant  out  NUM_REQ  one-hot, 1-cycle pulse: byte accepted.
- rbWriteEnable  out  1  to ring buffer writeEnable.
- rbWriteData  out  DATA_WIDTH  to ring buffer data.
- rbReadEnable  out  1  to ring buffer readEnable.
- rbReadAck  in  1  from ring buffer dataReadAck.
- rbReadData  in  DATA_WIDTH  from ring buffer dataRead.
- rdReq  in  1  consumer read request; level, sampled only in IDLE.
- rdValid  out  1  1-cycle pulse: rdData valid.
- rdData  out  DATA_WIDTH  byte read; holds its value until the next rdValid.
- rdErr  out  1  1-cycle pulse: read aborted on timeout.
- count  out  clog2(CAPACITY+1)  tracked occupancy.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.

Behaviour:
- Clock and reset: single clock, clk. reset is synchronous and active-high.
- Reset: grant=0, rbWriteEnable=0, rbWriteData=0, rbReadEnable=0, rdValid=0, rdData=0, rdErr=0, count=0, full=0, empty=1, rr pointer=0, read FSM=IDLE.
- Reset also forces rbWriteEnable=0 and rbReadEnable=0 in the cycle it is asserted. Reset mid-read abandons the read with no rdValid or rdErr. The ring buffer is reset by the same reset, so count=0 stays consistent with it.
- Write arbitration, every cycle:
  - A write is allowed when some req[i]=1 and count < CAPACITY.
  - Winner is the first requesting index at or after the rr pointer, wrapping modulo NUM_REQ.
  - At the clock edge: grant[winner]<=1, rbWriteEnable<=1, rbWriteData<=reqData[winner], rr pointer<=winner+1 (wraps).
  - Result: one-cycle latency from sampled req to grant and write. Back-to-back writes every cycle are allowed.
- Producer handshake:
  - The producer sees grant in the cycle after it was sampled. It must drop req, or present its next byte, in the cycle grant is high.
  - A req still high in the grant cycle is re-arbitrated as a new request. Round-robin guarantees other requesters are served first.
- Read FSM (IDLE, ISSUE, WAIT):
  - IDLE: if rdReq && !empty -> ISSUE, with rbReadEnable<=1 for exactly one cycle. rdReq with empty=1 is ignored.
  - ISSUE -> WAIT unconditionally. The timer starts at 0.
  - WAIT: on rbReadAck -> rdData<=rbReadData, rdValid<=1 for one cycle, count decrements, -> IDLE.
  - WAIT timeout: when the timer reaches ACK_TIMEOUT with no ack -> rdErr pulses one cycle, count<=0 (resync: buffer treated as empty), -> IDLE.
  - An rbReadAck arriving in ISSUE is accepted as in WAIT.
- count update, at the edge where the event is registered:
  - +1 for a write grant.
  - -1 for an accepted ack.
  - Both in the same cycle: count unchanged.
  - Never wraps. A write is only granted when count < CAPACITY. A read is only issued when count > 0.
  - Timeout resync to 0 takes priority over a same-cycle grant: the grant still fires, and count becomes 1.
- full and empty are combinational from count.

Test Plan:
- Reset, then 5 idle cycles -> all outputs at reset values, empty=1, count=0.
- req=4'b0001, reqData[7:0]=8'h01 held 1 cycle -> next cycle grant=4'b0001, rbWriteEnable=1, rbWriteData=8'h01; count becomes 1.
- req=4'b1111 with bytes 8'h10/8'h20/8'h30/8'h40, all held -> grants in order 0,1,2 on consecutive cycles; full=1 at count=3; no grant and rbWriteEnable=0 while full.
- With count=3: rdReq=1 -> rbReadEnable pulse 1 cycle; bench acks 2 cycles later with 8'h10 -> rdValid=1, rdData=8'h10, count=2. Requester 3 granted next (rr wrap), writes 8'h40.
- Same-cycle write grant and rbReadAck at count=2 -> count stays 2, both rdValid and grant pulse.
- rdReq with count=2 and no ack for ACK_TIMEOUT=15 cycles -> rdErr pulse, count=0, empty=1, FSM IDLE. Assert reset during WAIT -> no rdValid or rdErr, count=0.

Source files
------------

// File: rtl/uart_ring_arbiter.sv
// uart_ring_arbiter: round-robin write arbiter and read sequencer for a UARTRingBuffer; producers req/reqData/grant, buffer rb*, consumer rdReq/rdValid/rdData/rdErr, occupancy count/full/empty
module uart_ring_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int CAPACITY    = 3,
  parameter int ACK_TIMEOUT = 15,
  localparam int CW = $clog2(CAPACITY + 1),
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          rbWriteEnable,
  output logic [DATA_WIDTH-1:0]         rbWriteData,
  output logic                          rbReadEnable,
  input  logic                          rbReadAck,
  input  logic [DATA_WIDTH-1:0]         rbReadData,
  input  logic                          rdReq,
  output logic                          rdValid,
  output logic [DATA_WIDTH-1:0]         rdData,
  output logic                          rdErr,
  output logic [CW-1:0]                 count,
  output logic                          full,
  output logic                          empty
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_n;
  logic [PW-1:0] rr, win, idx;
  logic any, wr_ok, ack_ok, tmo, rd_go;
  logic [7:0] timer;
  assign full  = count == CW'(CAPACITY);
  assign empty = count == '0;
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rr) + k) % NUM_REQ);
      if (req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  always_comb begin
    wr_ok  = any && (count < CW'(CAPACITY));
    rd_go  = state == IDLE && rdReq && !empty;
    ack_ok = rbReadAck && (state == ISSUE || state == WAIT);
    tmo    = state == WAIT && !rbReadAck && timer == 8'(ACK_TIMEOUT);
  end
  always_comb begin
    state_n = rd_go ? ISSUE : (ack_ok || tmo) ? IDLE : state == ISSUE ? WAIT : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rr            <= '0;
      timer         <= '0;
      grant         <= '0;
      rbWriteEnable <= 1'b0;
      rbWriteData   <= '0;
      rbReadEnable  <= 1'b0;
      rdValid       <= 1'b0;
      rdData        <= '0;
      rdErr         <= 1'b0;
      count         <= '0;
    end else begin
      state         <= state_n;
      grant         <= wr_ok ? NUM_REQ'(1) << win : '0;
      rbWriteEnable <= wr_ok;
      if (wr_ok) begin
        rbWriteData <= reqData[win*DATA_WIDTH +: DATA_WIDTH];
        rr          <= win == PW'(NUM_REQ - 1) ? '0 : win + 1'b1;
      end
      rbReadEnable  <= rd_go;
      rdValid       <= ack_ok;
      rdErr         <= tmo;
      if (ack_ok) rdData <= rbReadData;
      timer         <= state == WAIT ? timer + 8'd1 : 8'd0;
      // a timeout resyncs to empty, but a write granted on that same edge still lands
      count         <= tmo ? CW'(wr_ok) : count + CW'(wr_ok) - CW'(ack_ok);
    end
  end
endmodule

// File: tb/tb_uart_ring_arbiter.sv
// tb_uart_ring_arbiter: scoreboard bench for uart_ring_arbiter
module tb_uart_ring_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] reqData = '0;
  logic rbReadAck = 1'b0, rdReq = 1'b0;
  logic [7:0] rbReadData = '0;
  logic [3:0] grant;
  logic rbWriteEnable, rbReadEnable, rdValid, rdErr, full, empty;
  logic [7:0] rbWriteData, rdData;
  logic [1:0] count;
  typedef struct {logic [3:0] g; logic [7:0] d;} wr_t;
  wr_t wq[$];
  logic [7:0] rq[$];
  logic [1:0] eq[$];
  wr_t we;
  int total = 0, passed = 0;
  uart_ring_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .reqData(reqData), .grant(grant),
    .rbWriteEnable(rbWriteEnable), .rbWriteData(rbWriteData), .rbReadEnable(rbReadEnable),
    .rbReadAck(rbReadAck), .rbReadData(rbReadData), .rdReq(rdReq), .rdValid(rdValid),
    .rdData(rdData), .rdErr(rdErr), .count(count), .full(full), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic issue_read();
    rdReq = 1'b1;
    cyc(1);
    rdReq = 1'b0;
    chk("ren_pulse", rbReadEnable, 1);
    cyc(1);
    chk("ren_once", rbReadEnable, 0);
  endtask
  always @(negedge clk) if (!reset) begin
    if (rbWriteEnable) begin
      if (wq.size() == 0) chk("unexp_write", grant, 0);
      else begin
        we = wq.pop_front();
        chk("grant", grant, we.g);
        chk("wdata", rbWriteData, we.d);
      end
    end
    if (rdValid) begin
      if (rq.size() == 0) chk("unexp_rdvalid", rdValid, 0);
      else chk("rddata", rdData, rq.pop_front());
    end
    if (rdErr) begin
      if (eq.size() == 0) chk("unexp_rderr", rdErr, 0);
      else chk("count_after_err", count, eq.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    cyc(2);
    reset = 1'b0;
    cyc(5);
    chk("rst_grant", grant, 0);
    chk("rst_wen", rbWriteEnable, 0);
    chk("rst_wdata", rbWriteData, 0);
    chk("rst_ren", rbReadEnable, 0);
    chk("rst_rdvalid", rdValid, 0);
    chk("rst_rddata", rdData, 0);
    chk("rst_rderr", rdErr, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    rdReq = 1'b1;
    cyc(2);
    rdReq = 1'b0;
    chk("ren_when_empty", rbReadEnable, 0);
    wq.push_back('{4'b0001, 8'h01});
    req = 4'b0001;
    reqData[7:0] = 8'h01;
    cyc(1);
    req = '0;
    chk("wen_single", rbWriteEnable, 1);
    chk("count_single", count, 1);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("count_after_rst", count, 0);
    reqData = {8'h40, 8'h30, 8'h20, 8'h10};
    wq.push_back('{4'b0001, 8'h10});
    wq.push_back('{4'b0010, 8'h20});
    wq.push_back('{4'b0100, 8'h30});
    req = 4'b1111;
    cyc(1);
    req = 4'b1110;
    cyc(1);
    req = 4'b1100;
    cyc(1);
    req = 4'b1000;
    chk("count_full", count, 3);
    chk("full_flag", full, 1);
    cyc(1);
    chk("wen_while_full", rbWriteEnable, 0);
    chk("grant_while_full", grant, 0);
    issue_read();
    rbReadAck = 1'b1;
    rbReadData = 8'h10;
    rq.push_back(8'h10);
    wq.push_back('{4'b1000, 8'h40});
    cyc(1);
    rbReadAck = 1'b0;
    chk("count_after_ack", count, 2);
    cyc(1);
    req = '0;
    chk("count_after_wrap_write", count, 3);
    issue_read();
    rbReadAck = 1'b1;
    rbReadData = 8'h20;
    rq.push_back(8'h20);
    cyc(1);
    rbReadAck = 1'b0;
    chk("count_read2", count, 2);
    issue_read();
    rbReadAck = 1'b1;
    rbReadData = 8'h30;
    req = 4'b0001;
    reqData[7:0] = 8'h55;
    rq.push_back(8'h30);
    wq.push_back('{4'b0001, 8'h55});
    cyc(1);
    rbReadAck = 1'b0;
    req = '0;
    chk("count_ack_and_write", count, 2);
    chk("rdvalid_concurrent", rdValid, 1);
    chk("wen_concurrent", rbWriteEnable, 1);
    issue_read();
    cyc(15);
    chk("no_err_early", rdErr, 0);
    req = 4'b0010;
    reqData[15:8] = 8'h66;
    eq.push_back(2'd1);
    wq.push_back('{4'b0010, 8'h66});
    cyc(1);
    req = '0;
    chk("rderr_on_time", rdErr, 1);
    chk("count_err_with_write", count, 1);
    chk("empty_err_with_write", empty, 0);
    cyc(1);
    chk("rderr_one_cycle", rdErr, 0);
    issue_read();
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("count_rst_wait", count, 0);
    chk("empty_rst_wait", empty, 1);
    rbReadAck = 1'b1;
    rbReadData = 8'hEE;
    cyc(2);
    rbReadAck = 1'b0;
    chk("ack_idle_ignored", rdData, 0);
    cyc(20);
    chk("no_err_after_rst", rdErr, 0);
    chk("count_idle_end", count, 0);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("eq_drained", eq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
